itemp_gen: RTL and testbench

Unary temporal bitstream generator for the 16-bit unary-temporal systolic array. Sits directly downstream of the border input register, which supplies a sign bit and a (WIDTH-1)-bit magnitude. On a start request it latches that sign/magnitude pair. It then emits a temporal (thermometer) bitstream into the PE row: `mag` ones followed by zeros over one counting period, with the sign held alongside.

---
 rtl/itemp_gen.sv | 99 +++++++++
 tb/tb_itemp_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/itemp_gen.sv
// Unary temporal (thermometer) bitstream generator: latches sign/magnitude on start and
// emits mag ones then zeros over one counting period. Optional macro: ITEMP_EARLY_TERM_EN.
module itemp_gen #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             start,
   input  logic             i_sign,
   input  logic [WIDTH-2:0] i_abs,
   output logic             o_bit,
   output logic             o_sign,
   output logic             o_busy,
   output logic             o_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-2:0] CNT_LAST = '1;
   localparam logic [WIDTH-2:0] CNT_ONE  = {{(WIDTH-2){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-2:0] cnt_q, cnt_d;
   logic [WIDTH-2:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic             bit_q, bit_d;
   logic             terminal;

`ifdef ITEMP_EARLY_TERM_EN
   // Stop right after the last one; a zero magnitude still spends one enabled cycle.
   assign terminal = (mag_q == '0) || (cnt_q == (mag_q - CNT_ONE));
`else
   assign terminal = (cnt_q == CNT_LAST);
`endif

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      mag_d   = mag_q;
      sign_d  = sign_q;
      bit_d   = 1'b0;
      if (clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         mag_d   = '0;
         sign_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  mag_d   = i_abs;
                  sign_d  = i_sign;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (en) begin
                  bit_d = (cnt_q < mag_q);
                  cnt_d = cnt_q + CNT_ONE;
                  if (terminal) state_d = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         bit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mag_q   <= mag_d;
         sign_q  <= sign_d;
         bit_q   <= bit_d;
      end
   end

   assign o_bit  = bit_q;
   assign o_sign = sign_q;
   assign o_busy = (state_q == RUN);
   assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_itemp_gen.sv
// Randomized self-checking bench for itemp_gen at WIDTH=4 (period 8), reference model
// derived from counting enabled edges per run.
module tb_itemp_gen;

   localparam int WIDTH  = 4;
   localparam int PERIOD = 1 << (WIDTH - 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             clr;
   logic             start;
   logic             i_sign;
   logic [WIDTH-2:0] i_abs;
   logic             o_bit;
   logic             o_sign;
   logic             o_busy;
   logic             o_done;

   int checks   = 0;
   int failures = 0;

   itemp_gen #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .clr    (clr),
      .start  (start),
      .i_sign (i_sign),
      .i_abs  (i_abs),
      .o_bit  (o_bit),
      .o_sign (o_sign),
      .o_busy (o_busy),
      .o_done (o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic exp_sign);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_bit"},  o_bit,  0);
      check({tag, "_sign"}, o_sign, exp_sign);
   endtask

   // Number of enabled RUN edges a run lasts for a given magnitude.
   function automatic int run_len(input int mag);
`ifdef ITEMP_EARLY_TERM_EN
      return (mag == 0) ? 1 : mag;
`else
      return PERIOD;
`endif
   endfunction

   // mode 0: full run, 1: clr on the 3rd enabled RUN edge, 2: async reset mid-run.
   task automatic run(input int mag, input logic sg, input int mode, input int en_pct);
      int   n;
      int   len;
      int   guard;
      logic e;
      logic exp_bit;
      len   = run_len(mag);
      start = 1'b1;
      i_abs = (WIDTH-1)'(mag);
      i_sign = sg;
      en    = 1'($urandom);
      step();
      check("start_busy", o_busy, 1);
      check("start_bit",  o_bit,  0);
      check("start_sign", o_sign, sg);
      check("start_done", o_done, 0);
      n     = 0;
      guard = 0;
      while (n < len && guard < 200) begin
         e      = ($urandom_range(99) < en_pct);
         en     = e;
         start  = 1'($urandom);
         i_abs  = (WIDTH-1)'($urandom);
         i_sign = 1'($urandom);
         if (mode == 1 && e && n == 2) begin
            clr = 1'b1;
            step();
            clr   = 1'b0;
            start = 1'b0;
            check_idle("clr", 1'b0);
            step();
            check_idle("clr_after", 1'b0);
            return;
         end
         if (mode == 2 && n == 3) begin
            #2 rst_n = 1'b0;
            #1;
            check_idle("arst", 1'b0);
            start = 1'b0;
            step();
            #2 rst_n = 1'b1;
            #1;
            check_idle("arst_release", 1'b0);
            return;
         end
         step();
         guard++;
         if (e) begin
            exp_bit = (n < mag);
            n++;
         end else begin
            exp_bit = 1'b0;
         end
         check("run_bit",  o_bit,  exp_bit);
         check("run_sign", o_sign, sg);
         check("run_busy", o_busy, n < len);
         check("run_done", o_done, n == len);
      end
      check("run_len", n, len);
      // A stray start while DONE must be ignored.
      en    = 1'($urandom);
      start = 1'($urandom);
      step();
      start = 1'b0;
      check_idle("post_done", sg);
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      clr    = 1'b0;
      start  = 1'b0;
      i_sign = 1'b0;
      i_abs  = '0;
      #1;
      check_idle("reset", 1'b0);
      #12 rst_n = 1'b1;
      step();
      check_idle("reset_rel", 1'b0);

      run(5, 1'b0, 0, 100);
      run(3, 1'b1, 0, 60);
      run(0, 1'b1, 0, 100);
      run(7, 1'b0, 0, 100);
      run(7, 1'b1, 0, 50);
      run(6, 1'b1, 1, 70);
      run(2, 1'b0, 0, 100);
      run(5, 1'b1, 2, 80);
      run(4, 1'b1, 0, 100);
      for (int i = 0; i < 25; i++) begin
         run($urandom_range(PERIOD - 1), 1'($urandom), 0, $urandom_range(100, 30));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
